// File: rtl/fetch_unit.sv
// Fetch stage: issues one instruction-memory read per PC, captures the word and
// drives the IF/ID register plus the stall back to the fetch PC register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00400020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    input  logic        stall_d,
    input  logic        flush_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        stall_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] addr_r;
    logic [31:0] addr_next_s;
    logic        drop_r;
    logic        drop_next_s;
    logic [31:0] hold_r;
    logic [31:0] hold_next_s;
    logic        deliver_s;
    logic [31:0] deliver_data_s;
    logic        stall_f_s;

    // Control state, captured address, drop flag and held instruction word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ISSUE;
            addr_r  <= RESET_PC;
            drop_r  <= 1'b0;
            hold_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
            drop_r  <= drop_next_s;
            hold_r  <= hold_next_s;
        end
    end

    // Next-state, delivery and PC-stall decode
    always_comb begin
        state_next_s   = state_r;
        addr_next_s    = addr_r;
        drop_next_s    = drop_r;
        hold_next_s    = hold_r;
        deliver_s      = 1'b0;
        deliver_data_s = imem_rdata;
        stall_f_s      = 1'b1;
        case (state_r)
            ST_ISSUE: begin
                // A redirect here lets the PC load the target before any request is latched
                if (flush_d) begin
                    stall_f_s = 1'b0;
                end else begin
                    addr_next_s  = pc_f;
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (drop_r) begin
                        drop_next_s  = 1'b0;
                        state_next_s = ST_ISSUE;
                    end else if (flush_d) begin
                        stall_f_s    = 1'b0;
                        state_next_s = ST_ISSUE;
                    end else if (stall_d) begin
                        hold_next_s  = imem_rdata;
                        state_next_s = ST_HOLD;
                    end else begin
                        deliver_s    = 1'b1;
                        stall_f_s    = 1'b0;
                        state_next_s = ST_ISSUE;
                    end
                end else if (flush_d) begin
                    drop_next_s = 1'b1;
                    stall_f_s   = 1'b0;
                end else begin
                    stall_f_s = 1'b1;
                end
            end
            ST_HOLD: begin
                deliver_data_s = hold_r;
                if (flush_d) begin
                    stall_f_s    = 1'b0;
                    state_next_s = ST_ISSUE;
                end else if (!stall_d) begin
                    deliver_s    = 1'b1;
                    stall_f_s    = 1'b0;
                    state_next_s = ST_ISSUE;
                end else begin
                    stall_f_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_ISSUE;
            end
        endcase
    end

    // IF/ID pipeline register: flush beats stall, stall beats delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= 32'h0000_0000;
            pc_plus4_d <= 32'h0000_0000;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            valid_d <= 1'b0;
        end else if (stall_d) begin
            valid_d <= valid_d;
        end else if (deliver_s) begin
            instr_d    <= deliver_data_s;
            pc_plus4_d <= addr_r + 32'd4;
            valid_d    <= 1'b1;
        end else begin
            valid_d <= 1'b0;
        end
    end

    assign imem_req  = rst_n && (state_r != ST_HOLD);
    assign imem_addr = (state_r == ST_ISSUE) ? pc_f : addr_r;
    assign stall_f   = (!rst_n) ? 1'b1 : stall_f_s;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch stage datapath/control, directly downstream of the fetch PC register (reg_f).
- Takes the current PC, runs a req/ack read against instruction memory, and captures the returned word.
- Presents the IF/ID pipeline outputs (instr, PC+4, valid) to decode.
- Drives stall_f back to the PC register (enable = ~stall_f) so the PC advances exactly once per delivered or redirected instruction.

Parameters:
RESET_PC, 32'h00400020, address latched into addr_q on reset (matches PC register init value)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
pc_f  in  32  current PC from fetch PC register
stall_d  in  1  decode stall; IF/ID outputs must hold
flush_d  in  1  taken branch/jump in decode; discard in-flight/held fetch
imem_req  out  1  read request, level, held until ack
imem_addr  out  32  read address
imem_ack  in  1  one-cycle pulse, imem_rdata valid
imem_rdata  in  32  instruction word
stall_f  out  1  1 = PC register must not load
instr_d  out  32  IF/ID instruction
pc_plus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID contents valid (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - State=ISSUE; addr_q=RESET_PC; drop_q=0; hold_q=0.
  - instr_d=0; pc_plus4_d=0; valid_d=0.
  - imem_req forced 0 while rst_n=0; stall_f=1.
- ISSUE: imem_req=1, imem_addr=pc_f.
  - Edge: addr_q<=pc_f, ->WAIT.
  - imem_ack in ISSUE is ignored; memory latency is >=1 cycle after req rises.
  - flush_d in ISSUE: stall_f=0, no latch, stay ISSUE.
- WAIT: imem_req=1, imem_addr=addr_q.
  - On ack with drop_q=1: discard data, drop_q<=0, ->ISSUE, stall_f=1.
  - On ack with drop_q=0, flush_d=0, stall_d=0: deliver (see below), stall_f=0, ->ISSUE.
  - On ack with drop_q=0, flush_d=0, stall_d=1: hold_q<=imem_rdata, ->HOLD, stall_f=1.
  - flush_d without ack: drop_q<=1, stall_f=0 this cycle only.
  - flush_d with ack: discard data, ->ISSUE, stall_f=0.
- HOLD: imem_req=0.
  - stall_d=0 and flush_d=0: deliver hold_q, stall_f=0, ->ISSUE.
  - flush_d=1: discard, stall_f=0, ->ISSUE.
  - Otherwise stall_f=1.
- stall_f is combinational and is 0 only in the cycles listed above; 1 otherwise.
- IF/ID register update each edge, first matching rule applies:
  - flush_d=1: valid_d<=0, regardless of stall_d.
  - stall_d=1: hold all.
  - Deliver: instr_d<=data, pc_plus4_d<=addr_q+4, valid_d<=1.
  - Otherwise: valid_d<=0; instr_d and pc_plus4_d hold.
- pc_plus4_d is 32-bit modulo: 0xFFFFFFFC -> 0x00000000.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency.
- Reset mid-WAIT: the outstanding ack that follows arrives in ISSUE and is ignored.
- Invariant: at most one outstanding request.

Test Plan:
1. Reset: rst_n=0 -> valid_d=0, instr_d=0, pc_plus4_d=0, imem_req=0, stall_f=1. Release with pc_f=0x00400020 -> imem_req=1, imem_addr=0x00400020.
2. Normal fetch, latency 1: ack with rdata=0x20080005 -> stall_f=0 in ack cycle only; next edge instr_d=0x20080005, pc_plus4_d=0x00400024, valid_d=1. Next cycle req addr = new pc_f 0x00400024.
3. Decode stall: stall_d=1 during ack of 0x8C090004 -> HOLD, imem_req=0, stall_f=1, IF/ID unchanged. Drop stall_d after 3 cycles -> instr_d=0x8C090004, valid_d=1, stall_f=0 for exactly one cycle.
4. Flush in WAIT: flush_d=1 one cycle -> stall_f=0 that cycle, valid_d=0. Later ack (rdata 0xDEADBEEF) discarded, valid_d stays 0. Next imem_addr=0x00400100 (new pc_f).
5. Wrap: pc_f=0xFFFFFFFC, ack 0x00000000 -> pc_plus4_d=0x00000000, valid_d=1.
6. Reset mid-WAIT: assert rst_n=0 with request outstanding, then ack arrives after release -> ack ignored, valid_d=0, next issue uses pc_f. flush_d and stall_d both high -> valid_d=0.
